// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with ARM-style NZCV flags.
// Single-cycle ops go out one edge after acceptance. DIV/REM with a nonzero
// divisor go through an iterative restoring divider that produces one
// quotient bit per cycle.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int CH_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int M  = WIDTH - 1;
  localparam logic [WIDTH-1:0] LW = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t r_state, w_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  // Divider working registers. r_quo starts as the dividend and is shifted
  // left; quotient bits enter at the bottom as dividend bits leave the top.
  logic [WIDTH-1:0] r_quo, r_rem, r_dvs;
  logic             r_rem_op;
  logic [CW-1:0]    r_cnt;

  logic             w_accept, w_isdiv, w_bz, w_start_div;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [SW-1:0]    w_samt;
  logic [WIDTH:0]   w_sl, w_sr;
  logic [CH_BITS+1:0] w_sum, w_avg;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff, w_dres;

  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_isdiv     = (op == 4'd5) || (op == 4'd9);
  assign w_bz        = (b == '0);
  assign w_start_div = w_accept && w_isdiv && !w_bz;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign busy      = (r_state == S_DIV);

  assign w_add  = {1'b0, a} + {1'b0, b};
  assign w_sub  = a - b;
  assign w_prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  // The extra bit beyond the result catches the last bit shifted out.
  assign w_samt = b[SW-1:0];
  assign w_sl   = {1'b0, a} << w_samt;
  assign w_sr   = {a, 1'b0} >> w_samt;
  assign w_sum  = (CH_BITS+2)'(a[CH_BITS-1:0]) + (CH_BITS+2)'(a[2*CH_BITS-1:CH_BITS])
                + (CH_BITS+2)'(a[3*CH_BITS-1:2*CH_BITS]);
  assign w_avg  = w_sum / (CH_BITS+2)'(3);

  // Restoring step: the remainder fits back in WIDTH bits whenever the
  // subtraction is taken, so the low WIDTH bits of the difference suffice.
  assign w_trial = {r_rem, r_quo[M]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial[WIDTH-1:0] - r_dvs;
  assign w_dres  = r_rem_op ? r_rem : r_quo;

  // Single-cycle result and carry/overflow selection
  always_comb begin
    w_res = a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      4'd1: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[M] == b[M]) && (w_add[M] != a[M]);
      end
      4'd2: w_res = a & b;
      4'd3: begin
        w_res = w_sub;
        w_c   = (a >= b);
        w_v   = (a[M] != b[M]) && (w_sub[M] != a[M]);
      end
      4'd4: begin
        w_res = w_prod[WIDTH-1:0];
        w_v   = |w_prod[2*WIDTH-1:WIDTH];
      end
      // Only reached for divide by zero; the nonzero case goes through the divider.
      4'd5: begin
        w_res = '1;
        w_v   = 1'b1;
      end
      4'd9: begin
        w_res = a;
        w_v   = 1'b1;
      end
      4'd6: begin
        w_res = '0;
        if (b < LW) begin
          w_res = w_sl[WIDTH-1:0];
          w_c   = w_sl[WIDTH];
        end else if (b == LW) begin
          w_c = a[M];
        end
      end
      4'd7: begin
        w_res = '0;
        if (b < LW) begin
          w_res = w_sr[WIDTH:1];
          w_c   = w_sr[0];
        end else if (b == LW) begin
          w_c = a[0];
        end
      end
      4'd8:  w_res = WIDTH'(w_avg);
      4'd15: w_res = '0;
      default: w_res = a;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_div) w_next = S_DIV;
      S_DIV:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Divider: latch operands on start, then one restoring step per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_rem_op <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_start_div) begin
        r_quo    <= a;
        r_rem    <= '0;
        r_dvs    <= b;
        r_rem_op <= (op == 4'd9);
        r_cnt    <= '0;
      end
    end else if (r_state == S_DIV) begin
      r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output register: load a new result, otherwise hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (r_state == S_DONE) begin
      r_out_valid <= 1'b1;
      r_result    <= w_dres;
      r_flags     <= {w_dres[M], (w_dres == '0), 2'b00};
    end else if (w_accept && !w_start_div) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_flags     <= {w_res[M], (w_res == '0), w_c, w_v};
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the pipeline's combinational ALU, for the datapath and the camera/image stage. It accepts one operation per transaction over valid/ready, registers every result, and computes full ARM-style NZCV flags. Divide and remainder use an iterative unsigned restoring divider instead of a combinational divider. The pixel-average operation is generalised to a parametrised channel width.

Parameters:
WIDTH, 32, operand/result width in bits (>= 8)
CH_BITS, 8, pixel channel width for AVG; 3*CH_BITS <= WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
op  in  4  operation code, see Behaviour
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flags  out  4  {N,Z,C,V}, registered with result
busy  out  1  divider iterating

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset values: out_valid=0, result=0, flags=0, busy=0, state=IDLE. A reset asserted mid-operation, including mid-divide, aborts it. No result is produced. in_ready=1 on the first cycle after reset deasserts.
- Op codes: 0 BUF(a), 1 ADD, 2 AND, 3 SUB(a-b), 4 MUL (low WIDTH bits), 5 DIV (unsigned a/b), 6 SL (a<<b), 7 SR (logical a>>b), 8 AVG, 9 REM (unsigned a%b), 15 NOP (result 0). Codes 10-14 behave as BUF.
- Handshake: a transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from registered state and out_ready.
- Output: result and flags hold stable while out_valid && !out_ready. out_valid clears on out_valid && out_ready unless a new result loads in the same cycle.
- States: IDLE, DIV, DONE.
- IDLE: an accepted non-divide op loads result/flags next edge and sets out_valid. Latency 1; throughput 1 per cycle while out_ready=1.
- IDLE: an accepted DIV/REM with b!=0 goes to DIV. Latch a, b and op; clear the iteration counter; busy=1.
- IDLE: an accepted DIV/REM with b==0 is handled at latency 1. DIV gives all-ones, REM gives a, V=1.
- DIV: one quotient bit per cycle, MSB first, for WIDTH cycles. Then go to DONE with busy=0.
- DONE: load quotient (DIV) or remainder (REM) and set out_valid. Return to IDLE. Total latency WIDTH+2 edges from acceptance to out_valid.
- Inputs are ignored while state!=IDLE. in_valid during DIV is not consumed.
- Shifts: the shift amount is the full unsigned b. If b >= WIDTH, result=0. C = last bit shifted out; C=0 if b==0. For b >= WIDTH, C=0 except b==WIDTH, where C = a[WIDTH-1] for SL and a[0] for SR.
- AVG: (a[CH-1:0] + a[2CH-1:CH] + a[3CH-1:2CH]) / 3, integer truncation. Computed in CH_BITS+2 bits, zero-extended to WIDTH.
- Flags: N = result[WIDTH-1]; Z = (result==0).
- C flag: ADD carry-out. SUB is not-borrow (1 when a >= b unsigned). Shifts as above. 0 for all others.
- V flag: ADD/SUB signed overflow. MUL: 1 if the upper WIDTH bits of the full 2*WIDTH product are nonzero. DIV/REM: 1 on divide by zero. 0 for all others.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, flags 4'b1001, out_valid exactly 1 cycle after acceptance.
- SUB a=5, b=5 -> result 0, flags 4'b0110. SUB a=3, b=5 -> result 0xFFFFFFFE, flags 4'b1000.
- DIV a=100, b=7 -> result 14, busy high 32 cycles, in_ready low until out_valid, out_valid 34 edges after acceptance. REM same operands -> 2. DIV a=9, b=0 -> 0xFFFFFFFF, flags 4'b1001, latency 1.
- SL a=0x80000001, b=1 -> 0x00000002, C=1. SR a=0xF0, b=40 -> 0, flags 4'b0100. AVG a=0x00302010 -> 0x00000020. MUL a=0x10000, b=0x10000 -> 0, flags 4'b0101.
- Backpressure: out_ready=0 for 5 cycles after an ADD result -> result/flags stable, in_ready=0. Raising out_ready with in_valid held gives a back-to-back transfer; a stream of 8 ADDs completes in 8 cycles.
- Reset asserted 10 cycles into a DIV -> no out_valid, busy=0 and in_ready=1 after reset. A following ADD 2+3 returns 5.
